// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, fetch FSM encoding
// and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int FUNC_HI = 3;
    localparam int FUNC_LO = 0;
    localparam int JTGT_HI = 11;
    localparam int JTGT_LO = 0;
    localparam int BOFS_HI = 3;
    localparam int BOFS_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERROR  = 3'd4
    } fetch_state_e;

    // beq takes the branch on zero, bne on non-zero.
    function automatic logic branch_taken(input logic branch_not_equal,
                                          input logic alu_zero);
        return alu_zero ^ branch_not_equal;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jump target, PC-relative branch or
// sequential increment, all wrapping modulo 2^PC_W.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     instr,
    input  logic            branch,
    input  logic            branch_not_equal,
    input  logic            jump,
    input  logic            alu_zero,
    output logic [PC_W-1:0] next_pc
);

    logic signed [3:0] bofs;
    logic [PC_W-1:0]   bofs_ext;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jtgt;
    logic              unused_opc;

    assign bofs     = instr[BOFS_HI:BOFS_LO];
    assign bofs_ext = PC_W'(bofs);
    assign pc_inc   = pc + PC_W'(1);
    assign jtgt     = PC_W'(instr[JTGT_HI:JTGT_LO]);

    // Opcode bits are decoded elsewhere; only the target/offset fields matter here.
    assign unused_opc = ^instr[OPC_HI:OPC_LO];

    always_comb begin
        next_pc = pc_inc;
        if (jump) begin
            next_pc = jtgt;
        end else if (branch && branch_taken(branch_not_equal, alu_zero)) begin
            next_pc = pc_inc + bofs_ext;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing: owns the PC, fetches over req/ack, holds the
// instruction for execute and advances the PC on exec_done.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int          TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic [3:0]      func,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    input  logic            exec_done,
    input  logic            branch,
    input  logic            branch_not_equal,
    input  logic            jump,
    input  logic            alu_zero,
    input  logic            halt,
    output logic            halted,
    output logic            fetch_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_inc;
    logic [PC_W-1:0] next_pc;

    fetch_next_pc #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc               (pc_q),
        .instr            (instr_q),
        .branch           (branch),
        .branch_not_equal (branch_not_equal),
        .jump             (jump),
        .alu_zero         (alu_zero),
        .next_pc          (next_pc)
    );

    assign tmo_inc = tmo_q + TMO_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                tmo_d   = '0;
            end
            ST_FETCH: begin
                // An ack in the expiry cycle still completes the fetch.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_ISSUE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    pc_d = next_pc;
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                        tmo_d   = '0;
                    end
                end
            end
            ST_HALTED, ST_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[OPC_HI:OPC_LO];
    assign func        = instr_q[FUNC_HI:FUNC_LO];
    assign instr_valid = (state_q == ST_ISSUE);
    assign pc          = pc_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_err   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch/issue sequencing, next-PC cases,
// halt, fetch timeout and reset behaviour.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  func;
    logic        instr_valid;
    logic [11:0] pc;
    logic        exec_done;
    logic        branch;
    logic        branch_not_equal;
    logic        jump;
    logic        alu_zero;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_W     (12),
        .RESET_PC (12'h000),
        .TIMEOUT  (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ack         (imem_ack),
        .instr            (instr),
        .opcode           (opcode),
        .func             (func),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .exec_done        (exec_done),
        .branch           (branch),
        .branch_not_equal (branch_not_equal),
        .jump             (jump),
        .alu_zero         (alu_zero),
        .halt             (halt),
        .halted           (halted),
        .fetch_err        (fetch_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called in a FETCH cycle: ack with w, land in ISSUE.
    task automatic fetch_word(input string tag, input logic [15:0] w);
        check_eq({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check_eq({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic exec(input logic b, input logic bne, input logic j,
                        input logic z, input logic h);
        exec_done        = 1'b1;
        branch           = b;
        branch_not_equal = bne;
        jump             = j;
        alu_zero         = z;
        halt             = h;
        @(negedge clk);
        exec_done        = 1'b0;
        branch           = 1'b0;
        branch_not_equal = 1'b0;
        jump             = 1'b0;
        alu_zero         = 1'b0;
        halt             = 1'b0;
    endtask

    // Leaves the DUT in its first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; imem_rdata = 16'h0; imem_ack = 1'b0; exec_done = 1'b0;
        branch = 1'b0; branch_not_equal = 1'b0; jump = 1'b0; alu_zero = 1'b0; halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pc",    {20'd0, pc},          32'h0);
        check_eq("rst_instr", {16'd0, instr},       32'h0);
        check_eq("rst_vld",   {31'd0, instr_valid}, 32'd0);
        check_eq("rst_req",   {31'd0, imem_req},    32'd0);
        check_eq("rst_halt",  {31'd0, halted},      32'd0);
        check_eq("rst_err",   {31'd0, fetch_err},   32'd0);

        rst = 1'b0;
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check_eq("fetch0_addr", {20'd0, imem_addr}, 32'h0);
        fetch_word("f0", 16'h3105);
        check_eq("f0_opc",   {28'd0, opcode},   32'h3);
        check_eq("f0_func",  {28'd0, func},     32'h5);
        check_eq("f0_noreq", {31'd0, imem_req}, 32'd0);
        // Issue waits for exec_done; ack here must be ignored.
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 16'h0;
        check_eq("issue_hold_instr", {16'd0, instr}, 32'h3105);
        check_eq("issue_hold_vld", {31'd0, instr_valid}, 32'd1);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("seq_pc",   {20'd0, pc},          32'h1);
        check_eq("seq_addr", {20'd0, imem_addr},   32'h1);
        check_eq("seq_vld",  {31'd0, instr_valid}, 32'd0);

        // beq taken, offset -2 from pc 10
        fetch_word("j10a", 16'h600A);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("jmp_pc10", {20'd0, pc}, 32'd10);
        fetch_word("beq_t", 16'h400E);
        exec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("beq_taken_pc", {20'd0, pc}, 32'd9);
        fetch_word("j10b", 16'h600A);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch_word("beq_n", 16'h400E);
        exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("beq_not_pc", {20'd0, pc}, 32'd11);

        fetch_word("j4", 16'h6004);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch_word("bne_t", 16'h5007);
        exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("bne_taken_pc", {20'd0, pc}, 32'd12);
        fetch_word("bne_n", 16'h5007);
        exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("bne_not_pc", {20'd0, pc}, 32'd13);

        fetch_word("jfff", 16'h6FFF);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("jmp_pcfff", {20'd0, pc}, 32'hFFF);
        fetch_word("wrap", 16'h0000);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wrap_pc", {20'd0, pc}, 32'h0);

        fetch_word("jprio", 16'h6ABC);
        exec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("jmp_prio_pc", {20'd0, pc}, 32'hABC);

        fetch_word("j3", 16'h6003);
        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        fetch_word("hlt", 16'h0000);
        exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("halt_flag", {31'd0, halted},   32'd1);
        check_eq("halt_pc",   {20'd0, pc},       32'd4);
        check_eq("halt_req",  {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; exec_done = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0; exec_done = 1'b0;
        check_eq("halt_stay_req", {31'd0, imem_req}, 32'd0);
        check_eq("halt_stay_flag", {31'd0, halted},  32'd1);
        check_eq("halt_stay_pc",  {20'd0, pc},       32'd4);

        // Ack arriving in the expiry cycle wins.
        do_reset();
        check_eq("rst_clr_halt", {31'd0, halted}, 32'd0);
        repeat (14) @(negedge clk);
        check_eq("late_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 16'h1111;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 16'h0;
        check_eq("late_ack_vld", {31'd0, instr_valid}, 32'd1);
        check_eq("late_ack_err", {31'd0, fetch_err},   32'd0);
        check_eq("late_ack_instr", {16'd0, instr},     32'h1111);

        exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("jmp_111", {20'd0, pc}, 32'h111);
        repeat (14) @(negedge clk);
        check_eq("tmo14_req", {31'd0, imem_req},  32'd1);
        check_eq("tmo14_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        check_eq("tmo_err", {31'd0, fetch_err}, 32'd1);
        check_eq("tmo_req", {31'd0, imem_req},  32'd0);
        check_eq("tmo_pc",  {20'd0, pc},        32'h111);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 16'h0;
        check_eq("err_ack_instr", {16'd0, instr},       32'h1111);
        check_eq("err_ack_vld",   {31'd0, instr_valid}, 32'd0);
        check_eq("err_sticky",    {31'd0, fetch_err},   32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("err_rst_clr", {31'd0, fetch_err}, 32'd0);
        check_eq("err_rst_pc",  {20'd0, pc},        32'h0);
        @(negedge clk);
        check_eq("restart_req",  {31'd0, imem_req},  32'd1);
        check_eq("restart_addr", {20'd0, imem_addr}, 32'h0);

        // Reset in the middle of a fetch; the ack that follows is stale.
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 16'h0;
        check_eq("midrst_instr", {16'd0, instr},       32'h0);
        check_eq("midrst_vld",   {31'd0, instr_valid}, 32'd0);
        check_eq("midrst_req2",  {31'd0, imem_req},    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and sequencing block for the 16-bit RISC core. Owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and presents `opcode`/`func` to the control decoder. Takes the decoder's resolved `branch`/`branch_not_equal`/`jump` back, plus the ALU zero flag, and computes the next PC. Runs a fetch/issue loop with halt and fetch-timeout handling.

## Interface
Parameters:
- PC_W, 12, program counter / instruction address width in words
- RESET_PC, 0, PC value loaded on reset
- TIMEOUT, 15, consecutive un-acked fetch cycles before error (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  word address (= pc) while imem_req
- imem_rdata  in  16  instruction word, valid when imem_ack
- imem_ack  in  1  fetch complete; may be same cycle as first req
- instr  out  16  instruction register
- opcode  out  4  instr[15:12], to control decoder
- func  out  4  instr[3:0], to control decoder
- instr_valid  out  1  instr held for execution
- pc  out  PC_W  address of instr / current fetch
- exec_done  in  1  execute complete; qualifies the four inputs below
- branch  in  1  conditional branch instruction
- branch_not_equal  in  1  branch sense: 0 = beq, 1 = bne
- jump  in  1  unconditional jump
- alu_zero  in  1  ALU result zero (rs − rt)
- halt  in  1  stop after current instruction
- halted  out  1  sticky; fetch stopped by halt
- fetch_err  out  1  sticky; fetch timeout

## Operation
- States: IDLE, FETCH, ISSUE, HALTED, ERROR.
- IDLE: entered on reset; goes to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc stable. On ack: instr←imem_rdata, → ISSUE. Without ack: timeout counter +1. Counter reaching TIMEOUT → ERROR. Counter clears on entry to FETCH.
- ISSUE: instr_valid=1, instr/pc frozen. Waits for exec_done, then updates pc. → HALTED if halt=1, else → FETCH.
- Next PC, all modulo 2^PC_W (wraps):
  - jump=1: pc←instr[11:0], zero-extended or truncated to PC_W. Jump has priority over branch.
  - branch=1 and (alu_zero XOR branch_not_equal)=1: pc←pc+1+sext(instr[3:0]). Offset range −8..+7.
  - otherwise: pc←pc+1.
- HALTED: halted=1. pc keeps the next-PC value. No requests. Exit only by rst.
- ERROR: fetch_err=1, imem_req=0. pc holds the faulting address. Exit only by rst.
- imem_ack outside FETCH is ignored. exec_done outside ISSUE is ignored. halt outside ISSUE is ignored.

## Timing
- Reset values: pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, halted=0, fetch_err=0, state=IDLE, timeout counter=0.
- Cycle after rst deasserts: IDLE. Next cycle: FETCH with imem_req=1.
- Ack in the first FETCH cycle: instr_valid=1 in the next cycle. Minimum fetch latency is 1 cycle.
- exec_done in ISSUE: pc updates on that edge. Next cycle: instr_valid=0, imem_req=1 at the new pc. Peak throughput is one instruction per 2 cycles, plus memory wait.
- Ack and timeout expiry in the same cycle: ack wins, → ISSUE.
- rst mid-FETCH: imem_req=0 the next cycle. Any late ack is ignored.
- rst in any state overrides all other inputs.

## Structure
- Shared package (`cpu_pkg`):
  - opcode constants OP_RTYPE=0000, OP_LW=0001, OP_SW=0010, OP_ADDI=0011, OP_BEQ=0100, OP_BNE=0101, OP_JMP=0110
  - FSM state encoding
  - field positions: OPC 15:12, FUNC 3:0, JTGT 11:0, BOFS 3:0
- Sub-module `fetch_next_pc` (combinational): inputs pc, instr, branch, branch_not_equal, jump, alu_zero; output next_pc. FSM, counter and registers stay in the top module.

## Test plan
- Reset, then ack every cycle with rdata=16'h3105 at addr 0: imem_req=1 at addr 0. Next cycle instr_valid=1, opcode=3, func=5. exec_done with no branch → pc=1.
- At pc=10, instr=16'h400E, branch=1, bne=0, alu_zero=1: pc=10+1−2=9. Same inputs with alu_zero=0: pc=11.
- bne at pc=4, instr=16'h5007, alu_zero=0: pc=12. At pc=4095 (PC_W=12), no branch: pc wraps to 0.
- jump=1 and branch=1 together, instr=16'h6ABC: pc=12'hABC (jump priority).
- Ack withheld for 15 cycles: fetch_err=1, imem_req=0, pc unchanged. A later ack is ignored. rst clears fetch_err and restarts at RESET_PC.
- halt with exec_done at pc=3 (sequential): halted=1, pc=4, no further imem_req. rst mid-FETCH with ack on the next cycle: instr stays 0, instr_valid=0.
